// File: rtl/cnn_pkg.sv
// Shared widths, channel slicing and saturation helper for the CNN pixel path.
package cnn_pkg;

   localparam int PIX_W  = 8;
   localparam int RGB_W  = 24;
   localparam int COEF_W = 8;
   localparam int N_TAPS = 9;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   // Zero-extended 9-bit pixel times signed coefficient, then growth for 3- and 9-term sums.
   localparam int PROD_W = PIX_W + 1 + COEF_W;
   localparam int ROW_W  = PROD_W + 2;
   localparam int SUM_W  = ROW_W + 2;

   // Saturate a signed channel sum into an unsigned 8-bit pixel.
   function automatic logic [PIX_W-1:0] clampPix(input logic signed [SUM_W-1:0] x);
      logic signed [SUM_W-1:0] maxPix;
      maxPix = $signed(SUM_W'(255));
      if (x[SUM_W-1]) begin
         return '0;
      end else if (x > maxPix) begin
         return {PIX_W{1'b1}};
      end else begin
         return x[PIX_W-1:0];
      end
   endfunction

endpackage

// File: rtl/conv3x3_channel.sv
// One colour channel of the 3x3 convolution: products, row sums, total with shift and clamp.
module conv3x3_channel
   import cnn_pkg::*;
#(
   parameter int SHIFT = 4
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic [PIX_W-1:0]         iPix [N_TAPS],
   input  logic signed [COEF_W-1:0] iCoef [N_TAPS],
   input  logic                     iEn,
   output logic [PIX_W-1:0]         oPix
);

   logic signed [PROD_W-1:0] prod [N_TAPS];
   logic signed [ROW_W-1:0]  rowSum [3];
   logic signed [SUM_W-1:0]  total;
   logic signed [SUM_W-1:0]  shifted;

   // Stage 1: register all nine signed products.
   always_ff @(posedge iClk) begin
      for (int i = 0; i < N_TAPS; i++) begin
         prod[i] <= PROD_W'($signed({1'b0, iPix[i]})) * PROD_W'(iCoef[i]);
      end
   end

   // Stage 2: register one partial sum per window row.
   always_ff @(posedge iClk) begin
      for (int r = 0; r < 3; r++) begin
         rowSum[r] <= ROW_W'(prod[3*r]) + ROW_W'(prod[3*r+1]) + ROW_W'(prod[3*r+2]);
      end
   end

   assign total   = SUM_W'(rowSum[0]) + SUM_W'(rowSum[1]) + SUM_W'(rowSum[2]);
   assign shifted = total >>> SHIFT;

   // Stage 3: result only updates for a valid window so it holds between results.
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         oPix <= '0;
      end else if (iEn) begin
         oPix <= clampPix(shifted);
      end
   end

endmodule

// File: rtl/conv3x3_rgb888.sv
// 3x3 signed-kernel convolution on RGB888 windows with per-frame end pulse.
module conv3x3_rgb888
   import cnn_pkg::*;
#(
   parameter int WIDTH  = 24,
   parameter int HEIGHT = 7,
   parameter int SHIFT  = 4
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic [RGB_W-1:0]         iIn0,
   input  logic [RGB_W-1:0]         iIn1,
   input  logic [RGB_W-1:0]         iIn2,
   input  logic [RGB_W-1:0]         iIn3,
   input  logic [RGB_W-1:0]         iIn4,
   input  logic [RGB_W-1:0]         iIn5,
   input  logic [RGB_W-1:0]         iIn6,
   input  logic [RGB_W-1:0]         iIn7,
   input  logic [RGB_W-1:0]         iIn8,
   input  logic                     iValid,
   input  logic                     iCoefWe,
   input  logic [3:0]               iCoefAddr,
   input  logic signed [COEF_W-1:0] iCoefData,
   output logic [RGB_W-1:0]         oPixel,
   output logic                     oValid,
   output logic                     oDone
);

   localparam int OUT_COUNT = (WIDTH - 2) * (HEIGHT - 2);
   localparam int CNT_W     = $clog2(OUT_COUNT);

   logic signed [COEF_W-1:0] coef [N_TAPS];
   logic [RGB_W-1:0]         win  [N_TAPS];
   logic [PIX_W-1:0]         pixR [N_TAPS];
   logic [PIX_W-1:0]         pixG [N_TAPS];
   logic [PIX_W-1:0]         pixB [N_TAPS];
   logic [PIX_W-1:0]         resR;
   logic [PIX_W-1:0]         resG;
   logic [PIX_W-1:0]         resB;
   logic                     v1;
   logic                     v2;
   logic [CNT_W-1:0]         frameCnt;
   logic                     lastOut;

   // Coefficient bank; stage 1 samples the old value on a coincident write.
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         for (int i = 0; i < N_TAPS; i++) begin
            coef[i] <= '0;
         end
         coef[4] <= COEF_W'(1 << SHIFT);
      end else if (iCoefWe && (iCoefAddr < 4'd9)) begin
         coef[iCoefAddr] <= iCoefData;
      end
   end

   assign win[0] = iIn0;
   assign win[1] = iIn1;
   assign win[2] = iIn2;
   assign win[3] = iIn3;
   assign win[4] = iIn4;
   assign win[5] = iIn5;
   assign win[6] = iIn6;
   assign win[7] = iIn7;
   assign win[8] = iIn8;

   // Split each window pixel into its three channels.
   always_comb begin
      for (int i = 0; i < N_TAPS; i++) begin
         pixR[i] = win[i][R_HI:R_LO];
         pixG[i] = win[i][G_HI:G_LO];
         pixB[i] = win[i][B_HI:B_LO];
      end
   end

   conv3x3_channel #(.SHIFT(SHIFT)) uChanR (
      .iClk  (iClk),
      .iRst  (iRst),
      .iPix  (pixR),
      .iCoef (coef),
      .iEn   (v2),
      .oPix  (resR)
   );

   conv3x3_channel #(.SHIFT(SHIFT)) uChanG (
      .iClk  (iClk),
      .iRst  (iRst),
      .iPix  (pixG),
      .iCoef (coef),
      .iEn   (v2),
      .oPix  (resG)
   );

   conv3x3_channel #(.SHIFT(SHIFT)) uChanB (
      .iClk  (iClk),
      .iRst  (iRst),
      .iPix  (pixB),
      .iCoef (coef),
      .iEn   (v2),
      .oPix  (resB)
   );

   assign oPixel  = {resR, resG, resB};
   assign lastOut = (frameCnt == CNT_W'(OUT_COUNT - 1));

   // Valid travels alongside the data; the frame counter advances as each result lands.
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         v1       <= 1'b0;
         v2       <= 1'b0;
         oValid   <= 1'b0;
         oDone    <= 1'b0;
         frameCnt <= '0;
      end else begin
         v1     <= iValid;
         v2     <= v1;
         oValid <= v2;
         oDone  <= v2 && lastOut;
         if (v2) begin
            frameCnt <= lastOut ? '0 : frameCnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_rgb888.sv
// Scoreboard bench for conv3x3_rgb888: stimulus pushes expected results, monitor pops on oValid.
module tb_conv3x3_rgb888;

   localparam int OUT_COUNT = 110;

   logic              iClk = 1'b0;
   logic              iRst;
   logic [23:0]       iIn0, iIn1, iIn2, iIn3, iIn4, iIn5, iIn6, iIn7, iIn8;
   logic              iValid;
   logic              iCoefWe;
   logic [3:0]        iCoefAddr;
   logic signed [7:0] iCoefData;
   logic [23:0]       oPixel;
   logic              oValid;
   logic              oDone;

   typedef struct {
      logic [23:0] pix;
      logic        done;
      int          cyc;
   } expT;

   expT sb[$];
   expT monE;
   int  errors = 0;
   int  checks = 0;
   int  cyc    = 0;
   int  outCnt = 0;

   conv3x3_rgb888 dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iIn0      (iIn0),
      .iIn1      (iIn1),
      .iIn2      (iIn2),
      .iIn3      (iIn3),
      .iIn4      (iIn4),
      .iIn5      (iIn5),
      .iIn6      (iIn6),
      .iIn7      (iIn7),
      .iIn8      (iIn8),
      .iValid    (iValid),
      .iCoefWe   (iCoefWe),
      .iCoefAddr (iCoefAddr),
      .iCoefData (iCoefData),
      .oPixel    (oPixel),
      .oValid    (oValid),
      .oDone     (oDone)
   );

   always #5 iClk = ~iClk;

   always @(posedge iClk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic setWin(input logic [23:0] ctr, input logic [23:0] oth);
      iIn0 = oth; iIn1 = oth; iIn2 = oth;
      iIn3 = oth; iIn4 = ctr; iIn5 = oth;
      iIn6 = oth; iIn7 = oth; iIn8 = oth;
   endtask

   task automatic pushExp(input logic [23:0] pix);
      expT e;
      e.pix  = pix;
      e.done = (outCnt == OUT_COUNT - 1);
      e.cyc  = cyc + 3;
      sb.push_back(e);
      outCnt = (outCnt == OUT_COUNT - 1) ? 0 : outCnt + 1;
   endtask

   task automatic issue(input logic [23:0] ctr, input logic [23:0] oth, input logic [23:0] expPix);
      setWin(ctr, oth);
      iValid = 1'b1;
      pushExp(expPix);
      tick();
      iValid = 1'b0;
   endtask

   task automatic idle(input int n);
      iValid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic setCoef(input logic [3:0] addr, input logic [7:0] data);
      iCoefWe   = 1'b1;
      iCoefAddr = addr;
      iCoefData = data;
      tick();
      iCoefWe   = 1'b0;
   endtask

   task automatic setAllCoef(input logic [7:0] data);
      for (int a = 0; a < 9; a++) setCoef(4'(a), data);
   endtask

   task automatic doReset();
      iValid  = 1'b0;
      iCoefWe = 1'b0;
      iRst    = 1'b0;
      sb.delete();
      outCnt  = 0;
      tick();
      iRst    = 1'b1;
   endtask

   task automatic checkResetState();
      @(negedge iClk);
      check("rstPixel", 32'(oPixel), 32'h0);
      check("rstValid", 32'(oValid), 32'h0);
      check("rstDone", 32'(oDone), 32'h0);
      tick();
   endtask

   // Monitor: every presented result is matched against the oldest expectation.
   always @(negedge iClk) begin
      if (iRst === 1'b1) begin
         if (oDone) check("doneNeedsValid", 32'(oValid), 32'h1);
         if (oValid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpectedValid: got oValid=1 pixel %h expected no result (cycle %0d)", oPixel, cyc);
            end else begin
               monE = sb.pop_front();
               check("pixel", 32'(oPixel), 32'(monE.pix));
               check("done", 32'(oDone), 32'(monE.done));
               check("latency", 32'(cyc), 32'(monE.cyc));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [23:0] p;
      iRst = 1'b0; iValid = 1'b0; iCoefWe = 1'b0; iCoefAddr = '0; iCoefData = '0;
      setWin(24'h0, 24'h0);
      repeat (2) tick();
      doReset();
      checkResetState();

      // Identity kernel from reset.
      issue(24'h102030, 24'hFFFFFF, 24'h102030);
      idle(5);

      // Address 12 is out of range; must not alias onto the centre tap.
      setCoef(4'd12, 8'h00);
      issue(24'h405060, 24'h010203, 24'h405060);
      idle(5);

      // Full frame plus one, identity kernel, counter from zero.
      doReset();
      for (int i = 0; i < OUT_COUNT + 1; i++) begin
         p = {8'(i), 8'(255 - i), 8'(i * 3)};
         setWin(p, 24'hA5A5A5);
         iValid = 1'b1;
         pushExp(p);
         tick();
      end
      idle(5);

      // Box blur: 9*16 >>> 4 = 9.
      setAllCoef(8'd1);
      issue(24'h101010, 24'h101010, 24'h090909);
      idle(5);

      // Clamp high (and zero channel stays zero), then clamp low.
      setAllCoef(8'h7F);
      issue(24'hFF00FF, 24'hFF00FF, 24'hFF00FF);
      idle(5);
      setAllCoef(8'h80);
      issue(24'h808080, 24'h808080, 24'h000000);
      idle(5);

      // Coefficient write coincident with window A; B sees the new value.
      setAllCoef(8'h00);
      setCoef(4'd4, 8'd16);
      setWin(24'h080808, 24'h000000);
      iValid    = 1'b1;
      iCoefWe   = 1'b1;
      iCoefAddr = 4'd4;
      iCoefData = 8'sd32;
      pushExp(24'h080808);
      tick();
      iCoefWe = 1'b0;
      issue(24'h080808, 24'h000000, 24'h101010);
      idle(5);

      // Some results so the frame counter is mid-frame, then reset right behind a window.
      for (int i = 0; i < 5; i++) issue(24'h080808, 24'h000000, 24'h101010);
      idle(5);
      issue(24'h080808, 24'h000000, 24'h101010);
      doReset();
      checkResetState();
      idle(6);

      // Identity restored, frame restarts: oDone on the 110th result after reset.
      for (int i = 0; i < OUT_COUNT; i++) begin
         p = {8'(i + 7), 8'(i ^ 8'h5A), 8'(200 - i)};
         setWin(p, 24'h3C3C3C);
         iValid = 1'b1;
         pushExp(p);
         tick();
      end
      idle(6);

      check("queueEmpty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
